// File: rtl/fun_ctrl_pkg.sv
// Shared types and helpers for the fun_sweep_ctrl truth-table sequencer.
package fun_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  function automatic int tbl_depth(input int in_w);
    return 32'd1 << in_w;
  endfunction

endpackage

// File: rtl/fun_settle_cnt.sv
// Loadable down-counter timing the settle interval between driving a code and sampling it.
module fun_settle_cnt #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_r;

  // Count down from the loaded value and park at zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= W'(0);
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != W'(0)) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Last settle cycle is the one where the count sits at 1
  assign expire = (cnt_r == W'(1));

endmodule

// File: rtl/fun_sweep_ctrl.sv
// Sweeps every input code of the external `fun` block and records its output as a truth table.
// Optional FUN_CHECK_EN adds exp_tbl/mismatch to compare the captured table against a reference.
module fun_sweep_ctrl
  import fun_ctrl_pkg::*;
#(
  parameter int IN_W       = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 fun_out,
  output logic [IN_W-1:0]      fun_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**IN_W-1:0]   tbl
`ifdef FUN_CHECK_EN
  ,
  input  logic [2**IN_W-1:0]   exp_tbl,
  output logic [0:0]           mismatch
`endif
);

  localparam int DEPTH = tbl_depth(IN_W);
  localparam int CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [IN_W:0] LAST_CODE = {1'b0, {IN_W{1'b1}}};

  state_t        state_r, state_s;
  logic [IN_W:0] code_r, code_s;
  logic          load_s, expire_s, clr_s, cap_s, active_s;

  fun_settle_cnt #(.W(CNT_W)) u_settle (
    .clock    (clock),
    .reset    (reset),
    .load     (load_s),
    .load_val (CNT_W'(SETTLE_CYC)),
    .expire   (expire_s)
  );

  // Next-state and per-state strobes
  always_comb begin
    state_s = state_r;
    code_s  = code_r;
    load_s  = 1'b0;
    clr_s   = 1'b0;
    cap_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_APPLY;
          code_s  = {(IN_W+1){1'b0}};
          clr_s   = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_APPLY: begin
        load_s  = 1'b1;
        state_s = (SETTLE_CYC > 0) ? S_SETTLE : S_CAPTURE;
      end
      S_SETTLE: begin
        // A zero settle never enters SETTLE; the extra term keeps it from trapping here
        if (expire_s || (SETTLE_CYC == 0)) begin
          state_s = S_CAPTURE;
        end else begin
          state_s = S_SETTLE;
        end
      end
      S_CAPTURE: begin
        cap_s = 1'b1;
        if (code_r == LAST_CODE) begin
          state_s = S_DONE;
        end else begin
          code_s  = code_r + {{IN_W{1'b0}}, 1'b1};
          state_s = S_APPLY;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_comb begin
    active_s = 1'b0;
    case (state_s)
      S_APPLY, S_SETTLE, S_CAPTURE: active_s = 1'b1;
      default:                      active_s = 1'b0;
    endcase
  end

  // FSM state and sweep code
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      code_r  <= {(IN_W+1){1'b0}};
    end else begin
      state_r <= state_s;
      code_r  <= code_s;
    end
  end

  // Registered drive, status and truth-table capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fun_in <= {IN_W{1'b0}};
      busy   <= 1'b0;
      done   <= 1'b0;
      tbl    <= {DEPTH{1'b0}};
    end else begin
      fun_in <= active_s ? code_s[IN_W-1:0] : {IN_W{1'b0}};
      busy   <= active_s;
      done   <= (state_s == S_DONE);
      if (clr_s) begin
        tbl <= {DEPTH{1'b0}};
      end else if (cap_s) begin
        tbl[code_r[IN_W-1:0]] <= fun_out;
      end else begin
        tbl <= tbl;
      end
    end
  end

`ifdef FUN_CHECK_EN
  // Reference compare, latched on the done cycle and held until the next sweep
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mismatch <= 1'b0;
    end else if (state_r == S_DONE) begin
      mismatch <= (tbl != exp_tbl);
    end else if (clr_s) begin
      mismatch <= 1'b0;
    end else begin
      mismatch <= mismatch;
    end
  end
`endif

endmodule

// File: tb/tb_fun_sweep_ctrl.sv
// Scoreboard bench for fun_sweep_ctrl: majority fun (default params) and XOR3 fun (zero settle).
module tb_fun_sweep_ctrl;

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic [2:0] fun_in0, fun_in1;
  logic       busy0, busy1, done0, done1;
  logic [7:0] tbl0, tbl1;
  logic       fun_out0, fun_out1;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         sel      = 0;
  logic [7:0] exp_q[$];

  logic [2:0] obs_fun_in;
  logic       obs_busy, obs_done;
  logic [7:0] obs_tbl;

  always #5 clock = ~clock;

  assign fun_out0 = (fun_in0[0] & fun_in0[1]) | (fun_in0[0] & fun_in0[2]) | (fun_in0[1] & fun_in0[2]);
  assign fun_out1 = ^fun_in1;

`ifdef FUN_CHECK_EN
  logic [7:0] exp_tbl0 = 8'hE8;
  logic [7:0] exp_tbl1 = 8'h96;
  logic [0:0] mismatch0, mismatch1;
`endif

  fun_sweep_ctrl #(.IN_W(3), .SETTLE_CYC(2)) dut0 (
    .clock   (clock),
    .reset   (reset),
    .start   (start0),
    .fun_out (fun_out0),
    .fun_in  (fun_in0),
    .busy    (busy0),
    .done    (done0),
    .tbl     (tbl0)
`ifdef FUN_CHECK_EN
    ,
    .exp_tbl (exp_tbl0),
    .mismatch(mismatch0)
`endif
  );

  fun_sweep_ctrl #(.IN_W(3), .SETTLE_CYC(0)) dut1 (
    .clock   (clock),
    .reset   (reset),
    .start   (start1),
    .fun_out (fun_out1),
    .fun_in  (fun_in1),
    .busy    (busy1),
    .done    (done1),
    .tbl     (tbl1)
`ifdef FUN_CHECK_EN
    ,
    .exp_tbl (exp_tbl1),
    .mismatch(mismatch1)
`endif
  );

  always_comb begin
    if (sel == 1) begin
      obs_fun_in = fun_in1;
      obs_busy   = busy1;
      obs_done   = done1;
      obs_tbl    = tbl1;
    end else begin
      obs_fun_in = fun_in0;
      obs_busy   = busy0;
      obs_done   = done0;
      obs_tbl    = tbl0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_start(input logic v);
    if (sel == 1) start1 = v;
    else          start0 = v;
  endtask

  // One full sweep on the selected DUT; per = cycles per code
  task automatic sweep(input int which, input int per, input logic [7:0] exp_t, input bit mid);
    int         e;
    bit         got;
    logic [7:0] want;
    sel = which;
    exp_q.push_back(exp_t);
    set_start(1'b1);
    @(negedge clock);
    e   = 0;
    got = 1'b0;
    while (!got && e < 100) begin
      set_start((mid && e == 3 * per) ? 1'b1 : 1'b0);
      if (obs_done) begin
        got  = 1'b1;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check_val("done_edge", e, 8 * per);
        check_val("done_busy", obs_busy, 0);
        check_val("done_fun_in", obs_fun_in, 0);
        check_val("tbl", obs_tbl, want);
      end else begin
        check_val("fun_in", obs_fun_in, e / per);
        check_val("busy", obs_busy, 1);
        @(negedge clock);
        e++;
      end
    end
    set_start(1'b0);
    if (!got) check_val("done_timeout", e, 8 * per);
    @(negedge clock);
    check_val("done_pulse", obs_done, 0);
    check_val("idle_busy", obs_busy, 0);
    check_val("tbl_hold", obs_tbl, exp_t);
  endtask

  initial begin
    int n;
    // Reset state and quiet idle
    repeat (2) @(negedge clock);
    check_val("rst_fun_in", fun_in0, 0);
    check_val("rst_busy", busy0, 0);
    check_val("rst_done", done0, 0);
    check_val("rst_tbl", tbl0, 0);
    check_val("rst_tbl1", tbl1, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_val("idle_busy", busy0, 0);
      check_val("idle_done", done0 | done1, 0);
    end

    sweep(0, 4, 8'hE8, 1'b0);
    sweep(1, 2, 8'h96, 1'b0);
`ifdef FUN_CHECK_EN
    check_val("mismatch1", mismatch1, 0);
`endif
    sweep(0, 4, 8'hE8, 1'b1);

    // Reset in the middle of code 5
    sel    = 0;
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    n = 0;
    while (fun_in0 != 3'd5 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_val("reach_code5", fun_in0, 5);
    reset = 1'b1;
    #1;
    check_val("arst_fun_in", fun_in0, 0);
    check_val("arst_tbl", tbl0, 0);
    check_val("arst_busy", busy0, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    sweep(0, 4, 8'hE8, 1'b0);

`ifdef FUN_CHECK_EN
    exp_tbl0 = 8'hE8;
    sweep(0, 4, 8'hE8, 1'b0);
    check_val("mismatch_ok", mismatch0, 0);
    exp_tbl0 = 8'hE9;
    sweep(0, 4, 8'hE8, 1'b0);
    check_val("mismatch_bad", mismatch0, 1);
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    check_val("mismatch_clr", mismatch0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
